// File: rtl/dmem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dmem_ctrl_pkg
//   Shared types and constants for the data-memory access controller.
//   - state_t  : sequencer states
//   - req_id_t : which requester owns the operation in flight
//   - S_W / V_W / LANES / MEM_SIZE : default word width, vector width,
//     lanes per vector and memory depth in words
// -----------------------------------------------------------------------------
package dmem_ctrl_pkg;

  localparam int S_W      = 32;
  localparam int V_W      = 192;
  localparam int LANES    = V_W / S_W;
  localparam int MEM_SIZE = 30015;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    ERR   = 3'd4
  } state_t;

  typedef enum logic {
    REQ_PIPE = 1'b0,
    REQ_DMA  = 1'b1
  } req_id_t;

endpackage

// File: rtl/dmem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_rr_arbiter
//   Two-way round-robin arbiter between the pipeline and the DMA port.
//   A sole requester is granted; on a tie the requester that was not granted
//   last wins. The last-grant flop only moves when the parent accepts.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   i_p_valid   : pipeline request valid
//   i_d_valid   : DMA request valid
//   i_update    : grant was consumed this cycle, remember the winner
//   o_gnt_p     : pipeline granted (one-hot with o_gnt_d)
//   o_gnt_d     : DMA granted
// -----------------------------------------------------------------------------
module dmem_rr_arbiter
  import dmem_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_p_valid,
  input  logic i_d_valid,
  input  logic i_update,
  output logic o_gnt_p,
  output logic o_gnt_d
);

  req_id_t r_last;

  // Grant selection; last-grant resets to DMA so the pipeline wins the first tie.
  always_comb begin
    o_gnt_p = 1'b0;
    o_gnt_d = 1'b0;
    if (i_p_valid && i_d_valid) begin
      if (r_last == REQ_DMA) begin
        o_gnt_p = 1'b1;
      end else begin
        o_gnt_d = 1'b1;
      end
    end else if (i_p_valid) begin
      o_gnt_p = 1'b1;
    end else if (i_d_valid) begin
      o_gnt_d = 1'b1;
    end else begin
      o_gnt_p = 1'b0;
      o_gnt_d = 1'b0;
    end
  end

  // Remember who won the most recent accepted grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= REQ_DMA;
    end else if (i_update) begin
      r_last <= o_gnt_p ? REQ_PIPE : REQ_DMA;
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
//   Sequencer/arbiter in front of a single-word data memory. Shares the memory
//   between the core pipeline (scalar or LANES-word vector) and the image-loader
//   DMA (scalar). Vector accesses are split into one word beat per cycle and
//   vector read data is reassembled lane by lane.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   p_req_valid/p_req_ready       : pipeline request handshake
//   p_we, p_isVector, p_addr, p_wd: pipeline request fields
//   p_rsp_valid, p_rd, p_err      : pipeline completion pulse, read data, error
//   d_req_valid/d_req_ready       : DMA request handshake
//   d_we, d_addr, d_wd            : DMA request fields
//   d_rsp_valid, d_rd, d_err      : DMA completion pulse, read data, error
//   m_we, m_addr, m_wd, m_rd      : memory port (m_rd answers last cycle's m_addr)
//   busy                          : controller not idle
// -----------------------------------------------------------------------------
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int S    = S_W,
  parameter int V    = V_W,
  parameter int SIZE = MEM_SIZE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         p_req_valid,
  output logic         p_req_ready,
  input  logic         p_we,
  input  logic         p_isVector,
  input  logic [S-1:0] p_addr,
  input  logic [V-1:0] p_wd,
  output logic         p_rsp_valid,
  output logic [V-1:0] p_rd,
  output logic         p_err,
  input  logic         d_req_valid,
  output logic         d_req_ready,
  input  logic         d_we,
  input  logic [S-1:0] d_addr,
  input  logic [S-1:0] d_wd,
  output logic         d_rsp_valid,
  output logic [S-1:0] d_rd,
  output logic         d_err,
  output logic         m_we,
  output logic [S-1:0] m_addr,
  output logic [S-1:0] m_wd,
  input  logic [S-1:0] m_rd,
  output logic         busy
);

  localparam int NL = V / S;
  localparam int LW = (NL > 1) ? $clog2(NL) : 1;

  // Sequencer state and latched request
  state_t        r_state;
  state_t        w_state_n;
  logic [LW-1:0] r_lane;
  logic [LW-1:0] w_lane_n;
  logic [LW-1:0] r_last;
  logic          r_we;
  req_id_t       r_id;
  logic [S-1:0]  r_addr;
  logic [V-1:0]  r_wd;

  // Read capture pipeline: marks the cycle in which m_rd belongs to us
  logic          r_cap_en;
  logic [LW-1:0] r_cap_lane;
  req_id_t       r_cap_id;

  // Registered outputs
  logic          r_m_we;
  logic [S-1:0]  r_m_addr;
  logic [S-1:0]  r_m_wd;
  logic          r_p_rsp_valid;
  logic          r_p_err;
  logic [V-1:0]  r_p_rd;
  logic          r_d_rsp_valid;
  logic          r_d_err;
  logic [S-1:0]  r_d_rd;

  // Arbitration and selected request
  logic          w_gnt_p;
  logic          w_gnt_d;
  logic          w_idle;
  logic          w_accept;
  req_id_t       w_sel_id;
  logic          w_sel_we;
  logic          w_sel_vec;
  logic [S-1:0]  w_sel_addr;
  logic [V-1:0]  w_sel_wd;
  logic [LW-1:0] w_sel_last;
  logic [S:0]    w_sel_end;
  logic          w_sel_bad;

  // Source of the beat driven next cycle
  logic          w_beat_en;
  logic          w_src_we;
  logic [S-1:0]  w_src_addr;
  logic [V-1:0]  w_src_wd;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle && (w_gnt_p || w_gnt_d);

  dmem_rr_arbiter u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_p_valid(p_req_valid),
    .i_d_valid(d_req_valid),
    .i_update (w_accept),
    .o_gnt_p  (w_gnt_p),
    .o_gnt_d  (w_gnt_d)
  );

  assign p_req_ready = w_idle && w_gnt_p;
  assign d_req_ready = w_idle && w_gnt_d;

  // Mux the granted request and range-check it in S+1 bits so the end address cannot wrap.
  always_comb begin
    w_sel_id   = REQ_PIPE;
    w_sel_we   = 1'b0;
    w_sel_vec  = 1'b0;
    w_sel_addr = {S{1'b0}};
    w_sel_wd   = {V{1'b0}};
    if (w_gnt_p) begin
      w_sel_id   = REQ_PIPE;
      w_sel_we   = p_we;
      w_sel_vec  = p_isVector;
      w_sel_addr = p_addr;
      w_sel_wd   = p_wd;
    end else begin
      w_sel_id   = REQ_DMA;
      w_sel_we   = d_we;
      w_sel_vec  = 1'b0;
      w_sel_addr = d_addr;
      w_sel_wd   = {{(V-S){1'b0}}, d_wd};
    end
    w_sel_last = w_sel_vec ? LW'(NL - 1) : {LW{1'b0}};
    w_sel_end  = {1'b0, w_sel_addr} + {{(S+1-LW){1'b0}}, w_sel_last};
    w_sel_bad  = (w_sel_end > (S+1)'(SIZE - 1));
  end

  // Next-state and lane-counter logic.
  always_comb begin
    w_state_n = r_state;
    w_lane_n  = r_lane;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_n = w_sel_bad ? ERR : ISSUE;
          w_lane_n  = {LW{1'b0}};
        end else begin
          w_state_n = IDLE;
        end
      end
      ISSUE: begin
        if (r_lane == r_last) begin
          w_state_n = r_we ? RESP : WAIT;
        end else begin
          w_lane_n = r_lane + 1'b1;
        end
      end
      WAIT:    w_state_n = RESP;
      RESP:    w_state_n = IDLE;
      ERR:     w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  // Memory outputs are registered, so the beat for next cycle is built from the
  // live request on the accept edge and from the latched request afterwards.
  always_comb begin
    w_beat_en = (w_state_n == ISSUE);
    if (w_idle) begin
      w_src_we   = w_sel_we;
      w_src_addr = w_sel_addr;
      w_src_wd   = w_sel_wd;
    end else begin
      w_src_we   = r_we;
      w_src_addr = r_addr;
      w_src_wd   = r_wd;
    end
  end

  // Sequencer, request latch, memory beat and response pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_lane        <= {LW{1'b0}};
      r_last        <= {LW{1'b0}};
      r_we          <= 1'b0;
      r_id          <= REQ_PIPE;
      r_addr        <= {S{1'b0}};
      r_wd          <= {V{1'b0}};
      r_cap_en      <= 1'b0;
      r_cap_lane    <= {LW{1'b0}};
      r_cap_id      <= REQ_PIPE;
      r_m_we        <= 1'b0;
      r_m_addr      <= {S{1'b0}};
      r_m_wd        <= {S{1'b0}};
      r_p_rsp_valid <= 1'b0;
      r_p_err       <= 1'b0;
      r_d_rsp_valid <= 1'b0;
      r_d_err       <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_lane  <= w_lane_n;
      if (w_accept) begin
        r_we   <= w_sel_we;
        r_id   <= w_sel_id;
        r_addr <= w_sel_addr;
        r_wd   <= w_sel_wd;
        r_last <= w_sel_last;
      end
      r_m_we   <= w_beat_en & w_src_we;
      r_m_addr <= w_beat_en ? (w_src_addr + {{(S-LW){1'b0}}, w_lane_n}) : {S{1'b0}};
      r_m_wd   <= w_beat_en ? w_src_wd[w_lane_n*S +: S] : {S{1'b0}};
      // A read beat on the bus now has its data on m_rd next cycle.
      r_cap_en   <= (r_state == ISSUE) && !r_we;
      r_cap_lane <= r_lane;
      r_cap_id   <= r_id;
      // Good completions pulse while in RESP; errors pulse on the way out of ERR.
      r_p_rsp_valid <= ((w_state_n == RESP) || (r_state == ERR)) && (r_id == REQ_PIPE);
      r_d_rsp_valid <= ((w_state_n == RESP) || (r_state == ERR)) && (r_id == REQ_DMA);
      r_p_err       <= (r_state == ERR) && (r_id == REQ_PIPE);
      r_d_err       <= (r_state == ERR) && (r_id == REQ_DMA);
    end
  end

  // Read data capture; scalar pipeline reads start from a zeroed upper vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_rd <= {V{1'b0}};
      r_d_rd <= {S{1'b0}};
    end else if (w_accept && (w_sel_id == REQ_PIPE) && !w_sel_we && !w_sel_vec && !w_sel_bad) begin
      r_p_rd[V-1:S] <= {(V-S){1'b0}};
    end else if (r_cap_en) begin
      if (r_cap_id == REQ_PIPE) begin
        r_p_rd[r_cap_lane*S +: S] <= m_rd;
      end else begin
        r_d_rd <= m_rd;
      end
    end
  end

  assign m_we        = r_m_we;
  assign m_addr      = r_m_addr;
  assign m_wd        = r_m_wd;
  assign p_rsp_valid = r_p_rsp_valid;
  assign p_err       = r_p_err;
  assign p_rd        = r_p_rd;
  assign d_rsp_valid = r_d_rsp_valid;
  assign d_err       = r_d_err;
  assign d_rd        = r_d_rd;
  assign busy        = (r_state != IDLE);

endmodule
